exe_mul_unit: RTL

- Iterative multi-cycle multiplier in the EXE stage. Executes the RV32M multiply ops that the ALU control decode selects: ALU_ctrl 10..13, i.e. mul, mulh, mulhsu, mulhu.
- Radix-2 shift-add core. Stalls the pipeline while it computes, then presents a 32-bit result for one cycle.
- Does not handle div/rem.

---
 rtl/exe_mul_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/exe_mul_unit.sv
// exe_mul_unit: iterative radix-2 shift-add multiplier for RV32M mul/mulh/mulhsu/mulhu.
// Stalls the pipeline while it computes, then presents the result for one cycle.
module exe_mul_unit #(
    parameter int                 XLEN      = 32,
    parameter int                 CTRL_W    = 5,
    parameter logic [CTRL_W-1:0]  OP_MUL    = 5'd10,
    parameter logic [CTRL_W-1:0]  OP_MULH   = 5'd11,
    parameter logic [CTRL_W-1:0]  OP_MULHSU = 5'd12,
    parameter logic [CTRL_W-1:0]  OP_MULHU  = 5'd13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [CTRL_W-1:0] ALU_ctrl,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [XLEN-1:0]   result_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CTRL_W-1:0]   op_q, op_d;
    logic                neg_q, neg_d;
    logic [XLEN-1:0]     a_q, a_d, b_q, b_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic                start, a_sgn, b_sgn, in_calc;
    logic [XLEN:0]       sum;

    assign start   = valid_i & ~flush_i & (ALU_ctrl >= OP_MUL) & (ALU_ctrl <= OP_MULHU);
    assign a_sgn   = ((ALU_ctrl == OP_MULH) | (ALU_ctrl == OP_MULHSU)) & rs1_data[XLEN-1];
    assign b_sgn   = (ALU_ctrl == OP_MULH) & rs2_data[XLEN-1];
    assign in_calc = (state_q == CALC) | (state_q == SIGN);
    // Upper half plus multiplicand keeps its carry as the bit shifted in on the right shift.
    assign sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, b_q[0] ? a_q : {XLEN{1'b0}}};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: if (start) begin
                state_d = CALC;
                op_d    = ALU_ctrl;
                a_d     = a_sgn ? -rs1_data : rs1_data;
                b_d     = b_sgn ? -rs2_data : rs2_data;
                neg_d   = a_sgn ^ b_sgn;
                prod_d  = '0;
                cnt_d   = '0;
            end
            CALC: if (flush_i) begin
                state_d = IDLE;
            end else begin
                prod_d  = {sum, prod_q[XLEN-1:1]};
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_LAST) ? SIGN : CALC;
            end
            SIGN: if (flush_i) begin
                state_d = IDLE;
            end else begin
                prod_d  = neg_q ? -prod_q : prod_q;
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    assign stall_o  = rst_n & (((state_q == IDLE) & start) | (in_calc & ~flush_i));
    assign busy_o   = in_calc;
    assign done_o   = state_q == DONE;
    assign result_o = !done_o ? '0 : (op_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
endmodule
